// File: rtl/freq_measure_ctrl.sv
// Gate-window frequency counter: counts rising edges of an async input over a
// programmable window of clk cycles in two-digit BCD, publishing once per window.
module freq_measure_ctrl #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                signal_in,
    output logic [3:0]          ten_count,
    output logic [3:0]          unit_count,
    output logic                load,
    output logic                overflow,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        LOAD
    } state_t;

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    state_t              state;
    logic                sync1;
    logic                sync2;
    logic                prev;
    logic                pulse;
    logic [PERIOD_W-1:0] win_len;
    logic [PERIOD_W-1:0] win_next;
    logic [PERIOD_W-1:0] timer;
    logic [3:0]          bcd_t;
    logic [3:0]          bcd_u;
    logic                sat;

    assign pulse    = sync2 & ~prev;
    assign win_next = (period == '0) ? ONE : period;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= signal_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            win_len    <= '0;
            timer      <= '0;
            bcd_t      <= 4'd0;
            bcd_u      <= 4'd0;
            sat        <= 1'b0;
            ten_count  <= 4'd0;
            unit_count <= 4'd0;
            load       <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            load <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= COUNT;
                        busy    <= 1'b1;
                        win_len <= win_next;
                        timer   <= '0;
                        bcd_t   <= 4'd0;
                        bcd_u   <= 4'd0;
                        sat     <= 1'b0;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer + ONE;
                        // at 99 further edges only flag saturation
                        if (pulse) begin
                            if (bcd_u != 4'd9) begin
                                bcd_u <= bcd_u + 4'd1;
                            end else if (bcd_t != 4'd9) begin
                                bcd_u <= 4'd0;
                                bcd_t <= bcd_t + 4'd1;
                            end else begin
                                sat <= 1'b1;
                            end
                        end
                        if (timer == win_len - ONE) begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    ten_count  <= bcd_t;
                    unit_count <= bcd_u;
                    overflow   <= sat;
                    load       <= 1'b1;
                    bcd_t      <= 4'd0;
                    bcd_u      <= 4'd0;
                    sat        <= 1'b0;
                    timer      <= '0;
                    if (enable) begin
                        state   <= COUNT;
                        win_len <= win_next;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
